// File: rtl/op_seq_pkg.sv
// Shared types for the element-wise operation sequencer.
package op_seq_pkg;

    localparam int unsigned OPCODE_W = 2;
    localparam int unsigned STATE_W  = 2;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_XOR = 2'd3
    } opcode_e;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/op_sequencer_alu.sv
// Combinational element operation: wrapping ADD/SUB, bitwise AND/XOR.
module op_alu
    import op_seq_pkg::*;
#(
    parameter int unsigned MEM_WIDTH = 32
) (
    input  opcode_e                opcode,
    input  logic [MEM_WIDTH-1:0]   a,
    input  logic [MEM_WIDTH-1:0]   b,
    output logic [MEM_WIDTH-1:0]   y
);

    always_comb begin
        y = '0;
        unique case (opcode)
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
            OP_AND: y = a & b;
            OP_XOR: y = a ^ b;
        endcase
    end

endmodule

// File: rtl/op_sequencer.sv
// Walks base..base+count-1 (wrapping), computes one result per element and
// issues back-pressured writes, pulsing done_o once the last write is taken.
module op_sequencer
    import op_seq_pkg::*;
#(
    parameter  int unsigned MEM_DEPTH = 8,
    parameter  int unsigned MEM_WIDTH = 32,
    localparam int unsigned AW        = $clog2(MEM_DEPTH),
    localparam int unsigned CW        = AW + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [AW-1:0]         base_addr_i,
    input  logic [CW-1:0]         count_i,
    input  logic [OPCODE_W-1:0]   opcode_i,
    output logic [AW-1:0]         operand1_addr_o,
    output logic [AW-1:0]         operand2_addr_o,
    input  logic [MEM_WIDTH-1:0]  operand1_i,
    input  logic [MEM_WIDTH-1:0]  operand2_i,
    output logic                  result_we_o,
    output logic [AW-1:0]         result_addr_o,
    output logic [MEM_WIDTH-1:0]  result_o,
    input  logic                  result_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    state_e                state_q, state_d;
    opcode_e               opcode_q, opcode_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         idx_q, idx_d;
    logic [AW-1:0]         addr_d;
    logic                  we_d, busy_d, done_d, err_d;
    logic [AW-1:0]         raddr_d;
    logic [MEM_WIDTH-1:0]  result_d;
    logic [MEM_WIDTH-1:0]  alu_y;
    logic                  count_ok_c;
    logic                  advance_c;
    logic                  last_c;

    op_alu #(.MEM_WIDTH(MEM_WIDTH)) u_alu (
        .opcode (opcode_q),
        .a      (operand1_i),
        .b      (operand2_i),
        .y      (alu_y)
    );

    assign count_ok_c = (count_i != '0) && (count_i <= CW'(MEM_DEPTH));
    assign advance_c  = !result_we_o || result_ready_i;
    assign last_c     = (idx_q == (count_q - CW'(1)));

    // Next-state and next-output logic; every register holds unless updated.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        count_d  = count_q;
        idx_d    = idx_q;
        addr_d   = operand1_addr_o;
        we_d     = result_we_o;
        raddr_d  = result_addr_o;
        result_d = result_o;
        busy_d   = busy_o;
        err_d    = err_o;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                addr_d = '0;
                if (start_i) begin
                    busy_d = 1'b1;
                    if (count_ok_c) begin
                        opcode_d = opcode_e'(opcode_i);
                        count_d  = count_i;
                        idx_d    = '0;
                        addr_d   = base_addr_i;
                        err_d    = 1'b0;
                        state_d  = S_RUN;
                    end else begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (advance_c) begin
                    result_d = alu_y;
                    raddr_d  = operand1_addr_o;
                    we_d     = 1'b1;
                    if (last_c) begin
                        addr_d  = '0;
                        state_d = S_DRAIN;
                    end else begin
                        idx_d  = idx_q + CW'(1);
                        addr_d = operand1_addr_o + AW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (result_we_o && result_ready_i) begin
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= S_IDLE;
            opcode_q        <= OP_ADD;
            count_q         <= '0;
            idx_q           <= '0;
            operand1_addr_o <= '0;
            result_we_o     <= 1'b0;
            result_addr_o   <= '0;
            result_o        <= '0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            err_o           <= 1'b0;
        end else begin
            state_q         <= state_d;
            opcode_q        <= opcode_d;
            count_q         <= count_d;
            idx_q           <= idx_d;
            operand1_addr_o <= addr_d;
            result_we_o     <= we_d;
            result_addr_o   <= raddr_d;
            result_o        <= result_d;
            busy_o          <= busy_d;
            done_o          <= done_d;
            err_o           <= err_d;
        end
    end

    // Both operand memories are always read at the same element address.
    assign operand2_addr_o = operand1_addr_o;

endmodule
